// File: rtl/input_mapper.sv
// input_mapper: maps PS/2 set-2 keyboard bytes and debounced active-low DB9
// joysticks onto per-player BCPPFRLDU button vectors. An ESC make also
// produces a timed reset request.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   kbd_valid     one-cycle strobe, kbd_scancode holds a new byte
//   kbd_scancode  PS/2 set-2 byte
//   db9_n         per player p: [6p+5:6p] = {p9,p6,right,left,down,up}, active-low
//   joy_out       per player p: [9p+8:9p] = {B,C,P2,P1,F,R,L,D,U}, active-high
//   reset_out     active-high reset request, RESET_PULSE_CYCLES long after ESC
//   kbd_active    high while any mapped keyboard key is held (ESC excluded)
//
// Optional build macro: INPUT_MAPPER_AUTOFIRE_EN gates each player's F output
// with a free-running phase that toggles every AUTOFIRE_HALF_PERIOD cycles.
`timescale 1ns/1ps

module input_mapper #(
    parameter int unsigned NUM_PLAYERS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES      = 50000,
    parameter int unsigned RESET_PULSE_CYCLES   = 1024,
    parameter int unsigned AUTOFIRE_HALF_PERIOD = 1500000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       kbd_valid,
    input  logic [7:0]                 kbd_scancode,
    input  logic [NUM_PLAYERS*6-1:0]   db9_n,
    output logic [NUM_PLAYERS*9-1:0]   joy_out,
    output logic                       reset_out,
    output logic                       kbd_active
);

    localparam int unsigned NB   = NUM_PLAYERS * 6;
    localparam int unsigned JW   = NUM_PLAYERS * 9;
    localparam int unsigned KW   = 18;
    localparam int unsigned PADW = 36;
    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW   = $clog2(RESET_PULSE_CYCLES + 1);
    localparam logic [KW-1:0] KEY_MASK = (NUM_PLAYERS >= 2) ? 18'h3FFFF : 18'h001FF;

    // Elaboration-time parameter sanity checks
    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
        $error("input_mapper: NUM_PLAYERS must be 1..4");
    end
    if (DEBOUNCE_CYCLES < 1 || RESET_PULSE_CYCLES < 1 || AUTOFIRE_HALF_PERIOD < 1) begin : g_bad_counts
        $error("input_mapper: cycle parameters must be nonzero");
    end

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    // Keyboard key-state bit for a code: P1 in [8:0], P2 in [17:9]
    function automatic logic [KW-1:0] key_map(input logic ext, input logic [7:0] code);
        logic [KW-1:0] m;
        m = '0;
        if (ext) begin
            case (code)
                8'h75: m[0] = 1'b1;
                8'h72: m[1] = 1'b1;
                8'h6B: m[2] = 1'b1;
                8'h74: m[3] = 1'b1;
                8'h11: m[8] = 1'b1;   // right alt aliases P1 B
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h29: m[4] = 1'b1;
                8'h11: m[8] = 1'b1;
                8'h16: begin m[5] = 1'b1; m[14] = 1'b1; end
                8'h1E: begin m[6] = 1'b1; m[15] = 1'b1; end
                8'h2E: m[7] = 1'b1;
                8'h1D: m[9] = 1'b1;
                8'h1B: m[10] = 1'b1;
                8'h1C: m[11] = 1'b1;
                8'h23: m[12] = 1'b1;
                8'h34: m[13] = 1'b1;
                8'h36: m[16] = 1'b1;
                8'h33: m[17] = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    state_t          state, state_next;
    logic [2:0]      skip_cnt, skip_next;
    logic            is_make, is_break, is_ext, esc_make;
    logic [KW-1:0]   key_state, key_next, key_sel;
    logic [PADW-1:0] key_pad;
    logic [PW-1:0]   pulse_cnt, pulse_next;
    logic [NB-1:0]   sync1, sync2, deb, deb_next;
    logic [CW-1:0]   db_cnt [NB];
    logic [CW-1:0]   db_cnt_next [NB];
    logic [JW-1:0]   joy_held, joy_next;

    // Decoder next-state and key events
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        is_make    = 1'b0;
        is_break   = 1'b0;
        is_ext     = 1'b0;
        if (kbd_valid) begin
            case (state)
                S_IDLE: begin
                    if (kbd_scancode == 8'hE0) begin
                        state_next = S_EXT;
                    end else if (kbd_scancode == 8'hF0) begin
                        state_next = S_BRK;
                    end else if (kbd_scancode == 8'hE1) begin
                        state_next = S_SKIP;
                        skip_next  = 3'd7;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (kbd_scancode == 8'hF0) begin
                        state_next = S_EXT_BRK;
                    end else begin
                        is_make    = 1'b1;
                        is_ext     = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    is_break   = 1'b1;
                    state_next = S_IDLE;
                end
                S_EXT_BRK: begin
                    is_break   = 1'b1;
                    is_ext     = 1'b1;
                    state_next = S_IDLE;
                end
                S_SKIP: begin
                    // Pause sequence tail: consumed without touching key state
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Key state update and ESC pulse counter
    always_comb begin
        key_sel  = key_map(is_ext, kbd_scancode) & KEY_MASK;
        key_next = key_state;
        if (is_make) begin
            key_next = key_state | key_sel;
        end else if (is_break) begin
            key_next = key_state & ~key_sel;
        end
        key_pad  = PADW'(key_next);
        esc_make = is_make && !is_ext && (kbd_scancode == 8'h76);
        pulse_next = pulse_cnt;
        if (esc_make) begin
            pulse_next = PW'(RESET_PULSE_CYCLES);
        end else if (pulse_cnt != '0) begin
            pulse_next = pulse_cnt - PW'(1);
        end
    end

    // Per-bit debounce: update after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        deb_next = deb;
        for (int i = 0; i < NB; i++) begin
            db_cnt_next[i] = db_cnt[i];
            if (sync2[i] == deb[i]) begin
                db_cnt_next[i] = '0;
            end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_next[i]    = sync2[i];
                db_cnt_next[i] = '0;
            end else begin
                db_cnt_next[i] = db_cnt[i] + CW'(1);
            end
        end
    end

    // Merge keyboard and DB9; C/P1/P2 come from the keyboard only
    always_comb begin
        joy_held = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            joy_held[9*p +: 9] = key_pad[9*p +: 9];
            joy_held[9*p +: 4] = joy_held[9*p +: 4] | ~deb_next[6*p +: 4];
            joy_held[9*p+4]    = joy_held[9*p+4] | ~deb_next[6*p+4];
            joy_held[9*p+8]    = joy_held[9*p+8] | ~deb_next[6*p+5];
        end
    end

`ifdef INPUT_MAPPER_AUTOFIRE_EN
    localparam int unsigned AW = $clog2(AUTOFIRE_HALF_PERIOD + 1);

    logic [AW-1:0] af_cnt, af_cnt_next;
    logic          af_phase, af_phase_next, fire_prev, fire_any;

    // Phase restarts high on the first F press so fire asserts at once
    always_comb begin
        fire_any = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            fire_any = fire_any | joy_held[9*p+4];
        end
        af_cnt_next   = af_cnt;
        af_phase_next = af_phase;
        if (fire_any && !fire_prev) begin
            af_cnt_next   = '0;
            af_phase_next = 1'b1;
        end else if (af_cnt == AW'(AUTOFIRE_HALF_PERIOD - 1)) begin
            af_cnt_next   = '0;
            af_phase_next = ~af_phase;
        end else begin
            af_cnt_next = af_cnt + AW'(1);
        end
        joy_next = joy_held;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            joy_next[9*p+4] = joy_held[9*p+4] & af_phase_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            af_cnt    <= '0;
            af_phase  <= 1'b0;
            fire_prev <= 1'b0;
        end else begin
            af_cnt    <= af_cnt_next;
            af_phase  <= af_phase_next;
            fire_prev <= fire_any;
        end
    end
`else
    assign joy_next = joy_held;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            skip_cnt   <= '0;
            key_state  <= '0;
            pulse_cnt  <= '0;
            sync1      <= '1;
            sync2      <= '1;
            deb        <= '1;
            joy_out    <= '0;
            reset_out  <= 1'b0;
            kbd_active <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            state      <= state_next;
            skip_cnt   <= skip_next;
            key_state  <= key_next;
            pulse_cnt  <= pulse_next;
            sync1      <= db9_n;
            sync2      <= sync1;
            deb        <= deb_next;
            joy_out    <= joy_next;
            reset_out  <= (pulse_next != '0);
            kbd_active <= |key_next;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_input_mapper.sv
// Self-checking bench for input_mapper (2 players, short debounce).
`timescale 1ns/1ps

module tb_input_mapper;

    localparam int unsigned NP  = 2;
    localparam int unsigned DEB = 16;
    localparam int unsigned RPC = 1024;
    localparam int unsigned AFH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        kbd_valid;
    logic [7:0]  kbd_scancode;
    logic [11:0] db9_n;
    logic [17:0] joy_out;
    logic        reset_out;
    logic        kbd_active;

    int checks = 0;
    int errors = 0;

    // Reference model: keyboard button bits and current stable DB9 input
    logic [17:0] mkeys;
    logic [11:0] mdb;

    typedef struct {
        logic       ext;
        logic [7:0] code;
        int         b0;
        int         b1;
    } key_t;

    typedef struct {
        logic [7:0]  code;
        logic [17:0] joy;
        logic        act;
    } vec_t;

    key_t keys[$];
    vec_t vecs[$];

    input_mapper #(
        .NUM_PLAYERS(NP),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_PULSE_CYCLES(RPC),
        .AUTOFIRE_HALF_PERIOD(AFH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kbd_valid(kbd_valid),
        .kbd_scancode(kbd_scancode),
        .db9_n(db9_n),
        .joy_out(joy_out),
        .reset_out(reset_out),
        .kbd_active(kbd_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        kbd_valid    = 1'b1;
        kbd_scancode = b;
        @(negedge clk);
        kbd_valid    = 1'b0;
    endtask

    task automatic add_key(input logic e, input logic [7:0] c, input int b0, input int b1);
        key_t k;
        k.ext = e; k.code = c; k.b0 = b0; k.b1 = b1;
        keys.push_back(k);
    endtask

    task automatic add_vec(input logic [7:0] c, input logic [17:0] j, input logic a);
        vec_t v;
        v.code = c; v.joy = j; v.act = a;
        vecs.push_back(v);
    endtask

    // Expected joy_out from the button-level model
    function automatic logic [17:0] exp_joy();
        logic [17:0] j;
        j = mkeys;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) j[9*p+k] = j[9*p+k] | ~mdb[6*p+k];
            j[9*p+4] = j[9*p+4] | ~mdb[6*p+4];
            j[9*p+8] = j[9*p+8] | ~mdb[6*p+5];
        end
        return j;
    endfunction

    initial begin
        logic [7:0] pause_seq [8];
        int hi;
        int lat;
        int g;
        logic seen;

        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        mkeys = '0;
        mdb   = '1;

        // Mapped keys (button bit indices) plus unmapped codes (-1)
        add_key(1'b1, 8'h75, 0, -1);  add_key(1'b1, 8'h72, 1, -1);
        add_key(1'b1, 8'h6B, 2, -1);  add_key(1'b1, 8'h74, 3, -1);
        add_key(1'b0, 8'h29, 4, -1);  add_key(1'b0, 8'h11, 8, -1);
        add_key(1'b1, 8'h11, 8, -1);  add_key(1'b0, 8'h16, 5, 14);
        add_key(1'b0, 8'h1E, 6, 15);  add_key(1'b0, 8'h2E, 7, -1);
        add_key(1'b0, 8'h1D, 9, -1);  add_key(1'b0, 8'h1B, 10, -1);
        add_key(1'b0, 8'h1C, 11, -1); add_key(1'b0, 8'h23, 12, -1);
        add_key(1'b0, 8'h34, 13, -1); add_key(1'b0, 8'h33, 17, -1);
        add_key(1'b0, 8'h36, 16, -1);
        add_key(1'b0, 8'h75, -1, -1); add_key(1'b0, 8'h72, -1, -1);
        add_key(1'b1, 8'h29, -1, -1); add_key(1'b1, 8'h1D, -1, -1);
        add_key(1'b0, 8'h1A, -1, -1); add_key(1'b0, 8'h5A, -1, -1);

        // Byte-by-byte vectors: joy_out/kbd_active after each byte
        add_vec(8'hE0, 18'h00000, 1'b0); add_vec(8'h75, 18'h00001, 1'b1);
        add_vec(8'hE0, 18'h00001, 1'b1); add_vec(8'hF0, 18'h00001, 1'b1);
        add_vec(8'h75, 18'h00000, 1'b0);
        for (int i = 0; i < 8; i++) add_vec(pause_seq[i], 18'h00000, 1'b0);
        add_vec(8'h29, 18'h00010, 1'b1); add_vec(8'hF0, 18'h00010, 1'b1);
        add_vec(8'h29, 18'h00000, 1'b0);
        add_vec(8'h1C, 18'h00800, 1'b1); add_vec(8'hF0, 18'h00800, 1'b1);
        add_vec(8'h1C, 18'h00000, 1'b0);
        add_vec(8'h16, 18'h04020, 1'b1); add_vec(8'hF0, 18'h04020, 1'b1);
        add_vec(8'h16, 18'h00000, 1'b0);
        add_vec(8'h11, 18'h00100, 1'b1); add_vec(8'hE0, 18'h00100, 1'b1);
        add_vec(8'hF0, 18'h00100, 1'b1); add_vec(8'h11, 18'h00000, 1'b0);
        add_vec(8'hF0, 18'h00000, 1'b0); add_vec(8'h33, 18'h00000, 1'b0);
        add_vec(8'h2E, 18'h00080, 1'b1); add_vec(8'h2E, 18'h00080, 1'b1);
        add_vec(8'hF0, 18'h00080, 1'b1); add_vec(8'h2E, 18'h00000, 1'b0);
        add_vec(8'h36, 18'h10000, 1'b1); add_vec(8'hF0, 18'h10000, 1'b1);
        add_vec(8'h36, 18'h00000, 1'b0);
        add_vec(8'h1E, 18'h08040, 1'b1); add_vec(8'h1D, 18'h08240, 1'b1);
        add_vec(8'hF0, 18'h08240, 1'b1); add_vec(8'h1E, 18'h00200, 1'b1);
        add_vec(8'hF0, 18'h00200, 1'b1); add_vec(8'h1D, 18'h00000, 1'b0);

        reset        = 1'b1;
        kbd_valid    = 1'b0;
        kbd_scancode = '0;
        db9_n        = '1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_joy", 32'(joy_out), 32'h0);
        chk("reset_active", 32'(kbd_active), 32'h0);
        chk("reset_rstout", 32'(reset_out), 32'h0);

        // Table-driven byte vectors
        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].code);
            chk($sformatf("vec%0d_joy", i), 32'(joy_out), 32'(vecs[i].joy));
            chk($sformatf("vec%0d_active", i), 32'(kbd_active), 32'(vecs[i].act));
            chk($sformatf("vec%0d_rstout", i), 32'(reset_out), 32'h0);
        end

        // DB9 glitch of DEB-2 cycles must not propagate
        seen = 1'b0;
        @(negedge clk);
        db9_n[0] = 1'b0;
        repeat (DEB - 2) begin
            @(negedge clk);
            if (joy_out[0]) seen = 1'b1;
        end
        db9_n[0] = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (joy_out[0]) seen = 1'b1;
        end
        chk("db9_glitch", 32'(seen), 32'h0);

        // Sustained press: visible after 2 sync + DEB cycles
        db9_n[0] = 1'b0;
        lat = 0;
        while (!joy_out[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("db9_press_latency", 32'(lat), 32'(DEB + 2));
        chk("db9_press_joy", 32'(joy_out), 32'h1);
        chk("db9_press_active", 32'(kbd_active), 32'h0);
        db9_n[0] = 1'b1;
        lat = 0;
        while (joy_out[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("db9_release_latency", 32'(lat), 32'(DEB + 2));

        // ESC pulse length
        send_byte(8'h76);
        chk("esc_active", 32'(kbd_active), 32'h0);
        chk("esc_joy", 32'(joy_out), 32'h0);
        hi = 0;
        while (reset_out && hi < 3000) begin
            hi++;
            @(negedge clk);
        end
        chk("esc_pulse_len", 32'(hi), 32'(RPC));
        send_byte(8'hF0);
        send_byte(8'h76);
        repeat (4) @(negedge clk);
        chk("esc_break_ignored", 32'(reset_out), 32'h0);

        // ESC reload after 500 cycles extends the pulse
        send_byte(8'h76);
        hi = 0;
        if (reset_out) hi++;
        repeat (499) begin
            @(negedge clk);
            if (reset_out) hi++;
        end
        kbd_valid    = 1'b1;
        kbd_scancode = 8'h76;
        @(negedge clk);
        kbd_valid = 1'b0;
        if (reset_out) hi++;
        g = 0;
        while (reset_out && g < 3000) begin
            @(negedge clk);
            g++;
            if (reset_out) hi++;
        end
        chk("esc_reload_len", 32'(hi), 32'(RPC + 500));
        send_byte(8'hF0);
        send_byte(8'h76);

        // Randomised key events and DB9 changes against the button model
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
            end else if (r < 12) begin
                db9_n = 12'($urandom);
                repeat (DEB + 4) @(negedge clk);
                mdb = db9_n;
            end else begin
                int idx;
                logic mk;
                idx = int'($urandom_range(0, keys.size() - 1));
                mk  = 1'($urandom_range(0, 1));
                if (keys[idx].ext) send_byte(8'hE0);
                if (!mk) send_byte(8'hF0);
                send_byte(keys[idx].code);
                if (keys[idx].b0 >= 0) mkeys[keys[idx].b0] = mk;
                if (keys[idx].b1 >= 0) mkeys[keys[idx].b1] = mk;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk($sformatf("rnd%0d_joy", n), 32'(joy_out), 32'(exp_joy()));
            chk($sformatf("rnd%0d_active", n), 32'(kbd_active), 32'(|mkeys));
        end

        db9_n = '1;
        repeat (DEB + 4) @(negedge clk);
        mdb = '1;

        // Reset mid-sequence with ESC counting and a byte on the same cycle
        send_byte(8'h76);
        send_byte(8'h29);
        send_byte(8'hE0);
        chk("pre_reset_rstout", 32'(reset_out), 32'h1);
        @(negedge clk);
        reset        = 1'b1;
        kbd_valid    = 1'b1;
        kbd_scancode = 8'h29;
        @(negedge clk);
        reset     = 1'b0;
        kbd_valid = 1'b0;
        mkeys     = '0;
        chk("midreset_joy", 32'(joy_out), 32'h0);
        chk("midreset_active", 32'(kbd_active), 32'h0);
        chk("midreset_rstout", 32'(reset_out), 32'h0);
        send_byte(8'h75);
        chk("post_reset_bare75", 32'(joy_out), 32'h0);
        send_byte(8'h29);
        chk("post_reset_fire", 32'(joy_out), 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_mapper.md
Name: input_mapper

Overview:
- Parametrised successor to the single-player keyboard-to-joystick translator.
- Decodes PS/2 set-2 scancode bytes, including extended, break and pause sequences, into per-player BCPPFRLDU button vectors.
- Merges those vectors with debounced, active-low DB9 joystick inputs for up to 4 players.
- Generates a timed system-reset pulse from the ESC key.
- Sits between io_ps2_keyboard and the arcade core's BUTTON inputs.

Parameters:
- NUM_PLAYERS, 2, player channels (1..4); keyboard map covers players 1-2 only, players 3-4 are DB9-only.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a DB9 bit's debounced value changes.
- RESET_PULSE_CYCLES, 1024, length of reset_out pulse.
- AUTOFIRE_HALF_PERIOD, 1500000, cycles per autofire half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- kbd_valid  in  1  one-cycle strobe: kbd_scancode holds a new byte
- kbd_scancode  in  8  PS/2 set-2 byte
- db9_n  in  NUM_PLAYERS*6  per player p, bits [6p+5:6p] = {p9,p6,right,left,down,up}, active-low
- joy_out  out  NUM_PLAYERS*9  per player, bits [9p+8:9p] = B,C,P2,P1,F,R,L,D,U, active-high
- reset_out  out  1  active-high reset request
- kbd_active  out  1  high while any mapped key is held

Behaviour:
- Reset (synchronous, active-high):
  - Clears all key-state bits, debounced DB9 state (to released), debounce counters, the decoder FSM (to IDLE), the pulse counter and the autofire phase.
  - All outputs read 0 on the cycle after reset is sampled high.
  - reset has priority over kbd_valid in the same cycle.
- Decoder FSM; acts only on cycles where kbd_valid=1.
  - States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP.
  - IDLE: E0->EXT; F0->BRK; E1->SKIP with skip counter=7; any other byte is a make of the normal code, stay IDLE.
  - EXT: F0->EXT_BRK; any other byte is an extended make, ->IDLE.
  - BRK: byte is a normal break, ->IDLE.
  - EXT_BRK: byte is an extended break, ->IDLE.
  - SKIP: decrement the counter per byte; ->IDLE after the 7th byte. Bytes consumed in SKIP never affect key state.
  - Make sets the mapped key bit; break clears it. Unmapped codes are ignored.
  - Repeated make is idempotent; break of an unheld key has no effect.
- Keymap (normal codes unless prefixed E0):
  - P1: U=E0 75, D=E0 72, L=E0 6B, R=E0 74, F=29 (space), B=11 (alt), P1=16 ('1'), P2=1E ('2'), C=2E ('5').
  - P2: U=1D, D=1B, L=1C, R=23, F=34, B=33, P1=16, P2=1E, C=36 ('6').
  - E0 11 (right alt) aliases to P1 B.
- Key-state latency: the joy_out bit changes on the clock edge that samples kbd_valid with the final byte of a sequence, and is visible the following cycle.
- DB9 path:
  - Each bit passes through a 2-flop synchroniser.
  - A per-bit counter resets whenever the synchronised value equals the debounced value; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1, the debounced value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Inverted debounced bits map to U,D,L,R,F(p6),B(p9).
- Output merge: joy_out = keyboard bits OR DB9 bits. The C, P1 and P2 bits come from the keyboard only.
- Reset pulse:
  - An ESC make (76) loads the counter with RESET_PULSE_CYCLES; reset_out=1 while the counter is nonzero.
  - The counter decrements each cycle, regardless of whether ESC is still held.
  - A new ESC make while counting reloads the counter (the pulse is extended).
  - The ESC break is ignored.
- kbd_active = OR of all mapped keyboard key-state bits, registered, and excludes ESC.

Optional Feature:
- Macro INPUT_MAPPER_AUTOFIRE_EN.
- Defined:
  - A free-running phase toggles every AUTOFIRE_HALF_PERIOD cycles.
  - Each player's F output = held_F AND phase, where held_F is the keyboard/DB9 fire hold.
  - The phase restarts at 1 (counter 0) on the first cycle any F goes from released to held, so fire asserts on the next cycle.
- Undefined: F = held_F; no autofire counter is synthesised.

Test Plan:
- Bytes E0,75 then E0,F0,75 -> joy_out[0] rises one cycle after the second byte and falls one cycle after the final 75; other bits remain 0.
- Bytes E1,14,77,E1,F0,14,F0,77 -> no joy_out change; FSM returns to IDLE. The following 29 -> P1 F (bit 4) set.
- Bytes 1C then F0,1C with NUM_PLAYERS=2 -> joy_out[11] (P2 L) pulses. Byte 16 -> bits 5 and 14 both set.
- db9_n bit 0 low for DEBOUNCE_CYCLES-2 cycles then high -> joy_out[0] stays 0. Held low continuously -> joy_out[0]=1 after sync+DEBOUNCE_CYCLES cycles.
- Byte 76 -> reset_out high for exactly 1024 cycles. A second 76 after 500 cycles -> total high time 1524 cycles.
- Assert reset mid-sequence (after E0, key 29 held) -> all outputs 0 next cycle. A subsequent bare 75 is treated as normal (unmapped) and joy_out stays 0.
